// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source IDs for the common-data-bus arbiter.
// Imported by cdb_fifo and cdb_arbiter.
package cdb_arbiter_pkg;

  localparam int RBID  = 4;
  localparam int CDB_W = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source completion FIFO: tag/value storage, pointers and count.
// A push into a full FIFO is dropped; fullness uses the pre-pop count.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = RBID,
  parameter int DATA_W = CDB_W,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_val,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_val,
  output logic              empty,
  output logic              full,
  output logic [PW:0]       count
);

  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [DATA_W-1:0] val_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign push_ok  = push & ~full & ~flush;
  assign pop_ok   = pop & ~empty & ~flush;
  assign head_tag = tag_mem[rd_ptr];
  assign head_val = val_mem[rd_ptr];

  // write the pushed entry at the tail
  always_ff @(posedge clk) begin
    if (push_ok) begin
      tag_mem[wr_ptr] <= push_tag;
      val_mem[wr_ptr] <= push_val;
    end
  end

  // advance pointers and track occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count
             + {{PW{1'b0}}, push_ok}
             - {{PW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two source FIFOs, round-robin grant, registered broadcast.
// Optional CDB_BYPASS_EN lets a result skip an empty FIFO (1-cycle latency).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int ROB_W        = RBID,
  parameter int STALL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             alu_flag,
  input  logic [ROB_W-1:0] alu_reorder,
  input  logic [CDB_W-1:0] alu_val,
  input  logic             lsb_flag,
  input  logic [ROB_W-1:0] lsb_reorder,
  input  logic [CDB_W-1:0] lsb_val,
  output logic             alu_stall,
  output logic             lsb_stall,
  output logic             cdb_flag,
  output logic [ROB_W-1:0] cdb_reorder,
  output logic [CDB_W-1:0] cdb_val
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] STALL_TH =
    (PW+1)'(FIFO_DEPTH - STALL_MARGIN);

  logic             act;
  src_t             last_grant;
  src_t             rr_src;
  src_t             gnt_src;
  logic             gnt_vld;
  logic             byp;

  logic             alu_push, lsb_push;
  logic             alu_pop, lsb_pop;
  logic             alu_empty, lsb_empty;
  logic             alu_full, lsb_full;
  logic [PW:0]      alu_cnt, lsb_cnt;
  logic [ROB_W-1:0] alu_head_tag, lsb_head_tag;
  logic [CDB_W-1:0] alu_head_val, lsb_head_val;
  logic [ROB_W-1:0] sel_tag;
  logic [CDB_W-1:0] sel_val;

  assign act    = rdy & ~flush;
  assign rr_src = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;

  assign alu_stall = (alu_cnt >= STALL_TH);
  assign lsb_stall = (lsb_cnt >= STALL_TH);

  // pick a source: FIFO heads first, bypass only when both are empty
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    byp     = 1'b0;
    unique case (1'b1)
      (!alu_empty && !lsb_empty): begin
        gnt_vld = 1'b1;
        gnt_src = rr_src;
      end
      (!alu_empty && lsb_empty): begin
        gnt_vld = 1'b1;
        gnt_src = SRC_ALU;
      end
      (alu_empty && !lsb_empty): begin
        gnt_vld = 1'b1;
        gnt_src = SRC_LSB;
      end
`ifdef CDB_BYPASS_EN
      (alu_empty && lsb_empty && alu_flag && lsb_flag): begin
        gnt_vld = 1'b1;
        gnt_src = rr_src;
        byp     = 1'b1;
      end
      (alu_empty && lsb_empty && alu_flag && !lsb_flag): begin
        gnt_vld = 1'b1;
        gnt_src = SRC_ALU;
        byp     = 1'b1;
      end
      (alu_empty && lsb_empty && !alu_flag && lsb_flag): begin
        gnt_vld = 1'b1;
        gnt_src = SRC_LSB;
        byp     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign alu_push = act & alu_flag & ~alu_full
                  & ~(byp & (gnt_src == SRC_ALU));
  assign lsb_push = act & lsb_flag & ~lsb_full
                  & ~(byp & (gnt_src == SRC_LSB));
  assign alu_pop  = act & gnt_vld & ~byp
                  & (gnt_src == SRC_ALU);
  assign lsb_pop  = act & gnt_vld & ~byp
                  & (gnt_src == SRC_LSB);

  // broadcast data mux: FIFO head or bypassed input
  always_comb begin
    sel_tag = alu_head_tag;
    sel_val = alu_head_val;
    case ({byp, gnt_src})
      {1'b0, SRC_ALU}: begin
        sel_tag = alu_head_tag;
        sel_val = alu_head_val;
      end
      {1'b0, SRC_LSB}: begin
        sel_tag = lsb_head_tag;
        sel_val = lsb_head_val;
      end
      {1'b1, SRC_ALU}: begin
        sel_tag = alu_reorder;
        sel_val = alu_val;
      end
      default: begin
        sel_tag = lsb_reorder;
        sel_val = lsb_val;
      end
    endcase
  end

  // output registers and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_flag    <= 1'b0;
      cdb_reorder <= '0;
      cdb_val     <= '0;
      last_grant  <= SRC_LSB;
    end else if (!act) begin
      cdb_flag <= 1'b0;
    end else begin
      cdb_flag <= gnt_vld;
      if (gnt_vld) begin
        cdb_reorder <= sel_tag;
        cdb_val     <= sel_val;
        last_grant  <= gnt_src;
      end
    end
  end

  cdb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .TAG_W  (ROB_W),
    .DATA_W (CDB_W),
    .PW     (PW)
  ) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (alu_push),
    .pop      (alu_pop),
    .push_tag (alu_reorder),
    .push_val (alu_val),
    .head_tag (alu_head_tag),
    .head_val (alu_head_val),
    .empty    (alu_empty),
    .full     (alu_full),
    .count    (alu_cnt)
  );

  cdb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .TAG_W  (ROB_W),
    .DATA_W (CDB_W),
    .PW     (PW)
  ) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (lsb_push),
    .pop      (lsb_pop),
    .push_tag (lsb_reorder),
    .push_val (lsb_val),
    .head_tag (lsb_head_tag),
    .head_val (lsb_head_val),
    .empty    (lsb_empty),
    .full     (lsb_full),
    .count    (lsb_cnt)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build).
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        alu_flag, lsb_flag;
  logic [3:0]  alu_reorder, lsb_reorder;
  logic [31:0] alu_val, lsb_val;
  logic        alu_stall, lsb_stall;
  logic        cdb_flag;
  logic [3:0]  cdb_reorder;
  logic [31:0] cdb_val;

  int vectors = 0;
  int errors  = 0;
  int a_tx, l_tx, a_rx, l_rx, k;

  cdb_arbiter #(
    .FIFO_DEPTH   (4),
    .ROB_W        (4),
    .STALL_MARGIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .flush       (flush),
    .alu_flag    (alu_flag),
    .alu_reorder (alu_reorder),
    .alu_val     (alu_val),
    .lsb_flag    (lsb_flag),
    .lsb_reorder (lsb_reorder),
    .lsb_val     (lsb_val),
    .alu_stall   (alu_stall),
    .lsb_stall   (lsb_stall),
    .cdb_flag    (cdb_flag),
    .cdb_reorder (cdb_reorder),
    .cdb_val     (cdb_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic af, input logic [3:0] at,
                       input logic [31:0] av,
                       input logic lf, input logic [3:0] lt,
                       input logic [31:0] lv);
    alu_flag    = af;
    alu_reorder = at;
    alu_val     = av;
    lsb_flag    = lf;
    lsb_reorder = lt;
    lsb_val     = lv;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    idle();

    // reset values
    do_reset();
    chk("rst_flag",  32'(cdb_flag),    32'h0);
    chk("rst_tag",   32'(cdb_reorder), 32'h0);
    chk("rst_val",   cdb_val,          32'h0);
    chk("rst_astl",  32'(alu_stall),   32'h0);
    chk("rst_lstl",  32'(lsb_stall),   32'h0);

    // single ALU result: 2-cycle latency, one broadcast
    drive(1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'h0);
    tick();
    idle();
    chk("t1_c1_flag", 32'(cdb_flag), 32'h0);
    tick();
    chk("t1_c2_flag", 32'(cdb_flag),    32'h1);
    chk("t1_c2_tag",  32'(cdb_reorder), 32'h3);
    chk("t1_c2_val",  cdb_val,          32'h1234);
    tick();
    chk("t1_c3_flag", 32'(cdb_flag), 32'h0);
    tick();
    chk("t1_c4_flag", 32'(cdb_flag), 32'h0);

    // simultaneous results from reset: ALU wins first tie
    do_reset();
    drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
    tick();
    idle();
    chk("t2_c1_flag", 32'(cdb_flag), 32'h0);
    tick();
    chk("t2_c2_flag", 32'(cdb_flag),    32'h1);
    chk("t2_c2_tag",  32'(cdb_reorder), 32'h1);
    chk("t2_c2_val",  cdb_val,          32'hA);
    tick();
    chk("t2_c3_flag", 32'(cdb_flag),    32'h1);
    chk("t2_c3_tag",  32'(cdb_reorder), 32'h2);
    chk("t2_c3_val",  cdb_val,          32'hB);
    tick();
    chk("t2_c4_flag", 32'(cdb_flag), 32'h0);

    // sustained contention honouring stall: strict alternation
    do_reset();
    a_tx = 0; l_tx = 0; a_rx = 0; l_rx = 0; k = 0;
    for (int c = 0; c < 12; c++) begin
      drive(!alu_stall, 4'(a_tx), 32'hA000 + 32'(a_tx),
            !lsb_stall, 4'(l_tx), 32'hB000 + 32'(l_tx));
      if (alu_flag) a_tx++;
      if (lsb_flag) l_tx++;
      tick();
      if (c == 1) begin
        chk("t3_lstl_on",  32'(lsb_stall), 32'h1);
        chk("t3_astl_off", 32'(alu_stall), 32'h0);
      end
      if (c == 2) chk("t3_astl_on", 32'(alu_stall), 32'h1);
      if (c >= 1) chk("t3_busy", 32'(cdb_flag), 32'h1);
      if (cdb_flag) begin
        if (k % 2 == 0) begin
          chk("t3_alt_atag", 32'(cdb_reorder), 32'(a_rx[3:0]));
          chk("t3_alt_aval", cdb_val, 32'hA000 + 32'(a_rx));
          a_rx++;
        end else begin
          chk("t3_alt_ltag", 32'(cdb_reorder), 32'(l_rx[3:0]));
          chk("t3_alt_lval", cdb_val, 32'hB000 + 32'(l_rx));
          l_rx++;
        end
        k++;
      end
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_flag) begin
        if (cdb_val[15:12] == 4'hA) begin
          chk("t3_drn_atag", 32'(cdb_reorder), 32'(a_rx[3:0]));
          chk("t3_drn_aval", cdb_val, 32'hA000 + 32'(a_rx));
          a_rx++;
        end else begin
          chk("t3_drn_ltag", 32'(cdb_reorder), 32'(l_rx[3:0]));
          chk("t3_drn_lval", cdb_val, 32'hB000 + 32'(l_rx));
          l_rx++;
        end
      end
    end
    chk("t3_alu_all", 32'(a_rx), 32'(a_tx));
    chk("t3_lsb_all", 32'(l_rx), 32'(l_tx));

    // flush with 3 results queued; last_grant survives the flush
    do_reset();
    drive(1'b1, 4'd5, 32'h50, 1'b1, 4'd6, 32'h60);
    tick();
    drive(1'b1, 4'd7, 32'h70, 1'b1, 4'd8, 32'h80);
    tick();
    chk("t4_pre_tag",  32'(cdb_reorder), 32'h5);
    chk("t4_pre_lstl", 32'(lsb_stall),   32'h1);
    drive(1'b1, 4'd9, 32'h90, 1'b1, 4'd9, 32'h91);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t4_fl_flag", 32'(cdb_flag),  32'h0);
    chk("t4_fl_astl", 32'(alu_stall), 32'h0);
    chk("t4_fl_lstl", 32'(lsb_stall), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_idle_flag", 32'(cdb_flag), 32'h0);
    end
    drive(1'b1, 4'd10, 32'hA0, 1'b1, 4'd11, 32'hB0);
    tick();
    idle();
    tick();
    chk("t4_rr_ltag", 32'(cdb_reorder), 32'hB);
    chk("t4_rr_lval", cdb_val,          32'hB0);
    tick();
    chk("t4_rr_atag", 32'(cdb_reorder), 32'hA);
    chk("t4_rr_aval", cdb_val,          32'hA0);
    tick();
    chk("t4_end_flag", 32'(cdb_flag), 32'h0);

    // rdy low for 3 cycles with 2 results queued
    do_reset();
    drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    tick();
    drive(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0);
    tick();
    chk("t5_pre_flag", 32'(cdb_flag),    32'h1);
    chk("t5_pre_tag",  32'(cdb_reorder), 32'h1);
    rdy = 1'b0;
    drive(1'b1, 4'd15, 32'hFF, 1'b1, 4'd14, 32'hEE);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_frz_flag", 32'(cdb_flag),    32'h0);
      chk("t5_frz_tag",  32'(cdb_reorder), 32'h1);
    end
    rdy = 1'b1;
    idle();
    tick();
    chk("t5_r1_flag", 32'(cdb_flag),    32'h1);
    chk("t5_r1_tag",  32'(cdb_reorder), 32'h2);
    chk("t5_r1_val",  cdb_val,          32'h22);
    tick();
    chk("t5_r2_tag",  32'(cdb_reorder), 32'h3);
    chk("t5_r2_val",  cdb_val,          32'h33);
    tick();
    chk("t5_end_flag", 32'(cdb_flag), 32'h0);

    // reset mid-stream
    do_reset();
    drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55);
    tick();
    drive(1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'h0);
    tick();
    chk("t6_pre_tag", 32'(cdb_reorder), 32'h4);
    rst = 1'b1;
    drive(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88);
    tick();
    rst = 1'b0;
    idle();
    chk("t6_rst_flag", 32'(cdb_flag),    32'h0);
    chk("t6_rst_tag",  32'(cdb_reorder), 32'h0);
    chk("t6_rst_val",  cdb_val,          32'h0);
    chk("t6_rst_astl", 32'(alu_stall),   32'h0);
    chk("t6_rst_lstl", 32'(lsb_stall),   32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_idle_flag", 32'(cdb_flag), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
